// File: rtl/router_pkg.sv
// Shared definitions for the packet-aware router output FIFO.
//   HDR_LSB     : low bit of the header length field (datain[DATA_W-1:HDR_LSB])
//   fifo_word_t : stored word {sof, data} at the default payload width
//   clog2_safe  : address width helper, never returns less than 1
package router_pkg;

    localparam int HDR_LSB    = 2;
    localparam int DATA_W_DEF = 8;

    typedef struct packed {
        logic                  sof;
        logic [DATA_W_DEF-1:0] data;
    } fifo_word_t;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Channel-side bus of the router FIFO.
//   slave  : the FIFO (takes write/read/flush requests, drives status + read data)
//   master : the router FSM / channel read port driving the requests
// Parameters DATA_W / DEPTH must match the attached router_fifo_pkt.
interface router_fifo_pkt_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                       soft_reset;
    logic                       write_en;
    logic                       read_en;
    logic                       lfd_state;
    logic [DATA_W-1:0]          datain;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic [DATA_W-1:0]          dataout;
    logic                       rd_sof;
    logic [DATA_W-2:0]          pkt_left;
    logic [$clog2(DEPTH):0]     pkt_cnt;
    logic                       err;

    modport slave (
        input  soft_reset, write_en, read_en, lfd_state, datain,
        output full, empty, almost_full, dataout, rd_sof, pkt_left, pkt_cnt, err
    );

    modport master (
        output soft_reset, write_en, read_en, lfd_state, datain,
        input  full, empty, almost_full, dataout, rd_sof, pkt_left, pkt_cnt, err
    );
endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// No reset on storage or read register; validity is tracked by the owner.
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata updates on the edge where re is high
module router_fifo_mem #(
    parameter int  DEPTH  = 16,
    parameter int  AW     = 4,
    parameter type word_t = router_pkg::fifo_word_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);
    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata      <= mem[raddr];
    end
endmodule

// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO (one per output channel).
// Ports: clk, reset (async, active high), bus (router_fifo_pkt_if.slave):
//   soft_reset/write_en/read_en/lfd_state/datain in;
//   full/empty/almost_full, dataout/rd_sof (1-cycle read latency),
//   pkt_left (reads left in current packet), pkt_cnt (headers stored), err out.
// Build option: define ROUTER_FIFO_ERR_EN for the sticky overflow/underflow flag;
// otherwise err is tied low.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 14
) (
    input  logic             clk,
    input  logic             reset,
    router_fifo_pkt_if.slave bus
);
    localparam int AW = clog2_safe(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic              sof;
        logic [DATA_W-1:0] data;
    } word_t;

    logic [PW-1:0]     wptr, rptr, occ;
    logic [PW-1:0]     cnt_q;
    logic [DATA_W-2:0] left_q, pkt_left, hdr_len;
    logic              rd_fresh, zero_q, hdr_now;
    logic              wr_ok, rd_ok;
    word_t             wdata, rdata;

    assign occ             = wptr - rptr;
    assign bus.full        = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign bus.empty       = (wptr == rptr);
    assign bus.almost_full = (occ >= PW'(AFULL_TH));

    assign wr_ok = bus.write_en && !bus.full;
    assign rd_ok = bus.read_en  && !bus.empty;

    assign wdata = '{sof: bus.lfd_state, data: bus.datain};

    router_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .word_t(word_t)) u_mem (
        .clk   (clk),
        .we    (wr_ok && !bus.soft_reset),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_ok && !bus.soft_reset),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

    // The header bit is only visible in rdata after the read edge, so the
    // effect of a freshly read header is applied combinationally on top of
    // the committed registers and folded into them on the following edge.
    assign hdr_now  = rd_fresh && rdata.sof;
    assign hdr_len  = {1'b0, rdata.data[DATA_W-1:HDR_LSB]} + 1'b1;
    assign pkt_left = hdr_now ? hdr_len : left_q;

    assign bus.pkt_left = pkt_left;
    assign bus.pkt_cnt  = cnt_q - PW'(hdr_now);

    // zero_q marks the idle state: the read register is masked to 0.
    assign bus.dataout  = zero_q ? '0 : rdata.data;
    assign bus.rd_sof   = !zero_q && rdata.sof;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt_q    <= '0;
            left_q   <= '0;
            rd_fresh <= 1'b0;
            zero_q   <= 1'b1;
        end else if (bus.soft_reset) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt_q    <= '0;
            left_q   <= '0;
            rd_fresh <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            cnt_q    <= cnt_q - PW'(hdr_now) + PW'(wr_ok && bus.lfd_state);
            rd_fresh <= rd_ok;
            // On a read, a header word overrides this via the pkt_left mux.
            if (rd_ok)
                left_q <= (pkt_left == '0) ? '0 : pkt_left - 1'b1;
            else
                left_q <= pkt_left;
            if (rd_ok)
                zero_q <= 1'b0;
            else if (pkt_left == '0)
                zero_q <= 1'b1;
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if ((bus.write_en && bus.full) || (bus.read_en && bus.empty))
            err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
Parametrised, packet-aware successor to the 16x9 router FIFO; one instance per router output channel, between the router FSM/register stage and the channel read port.
- Tags each stored word with a header marker (`lfd_state`).
- Tracks the remaining payload length of the packet being read.
- Keeps a count of complete packet headers held.
- Adds an `almost_full` threshold and a synchronous soft flush.

Parameters:
- `DATA_W`, 8: payload byte width; header length field is `datain[DATA_W-1:2]`.
- `DEPTH`, 16: number of entries; power of two, minimum 4.
- `AFULL_TH`, 14: occupancy at or above which `almost_full` asserts; must be less than or equal to `DEPTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `soft_reset` in 1: synchronous flush (channel read timeout).
- `write_en` in 1: write request.
- `read_en` in 1: read request.
- `lfd_state` in 1: current write is a header byte.
- `datain` in `DATA_W`: write data.
- `full` out 1: occupancy equals `DEPTH`.
- `empty` out 1: occupancy equals 0.
- `almost_full` out 1: occupancy is at least `AFULL_TH`.
- `dataout` out `DATA_W`: registered read data.
- `rd_sof` out 1: `dataout` currently holds a header byte.
- `pkt_left` out `DATA_W-1`: reads remaining in the current packet (payload plus parity).
- `pkt_cnt` out `$clog2(DEPTH)+1`: headers currently stored.
- `err` out 1: sticky overflow/underflow flag; see Optional Feature.

Behaviour:
- Reset (async, `reset`=1): pointers, occupancy, `pkt_cnt`, `pkt_left`, `dataout`, `rd_sof` and `err` all 0. Outputs: `empty`=1, `full`=0, `almost_full`=0.
- Storage: `DEPTH` x (`DATA_W`+1). Bit `DATA_W` stores `lfd_state` at write time. Memory contents are not reset.
- Pointers: `$clog2(DEPTH)`+1 bits each, with a wrap bit.
  - `full` when addresses are equal and wrap bits differ.
  - `empty` when pointers are fully equal.
  - Status flags are registered/derived from registered pointers and valid the same cycle the pointer updates.
- Write: accepted iff `write_en` and not `full`. A write while `full` is dropped and memory is unchanged. This holds even if `read_en` is high in the same cycle (no pass-through when full).
- Read: accepted iff `read_en` and not `empty`.
  - `dataout`/`rd_sof` update at the next rising edge (1-cycle latency).
  - A read while `empty` is ignored and `dataout` holds its value.
- Simultaneous read and write, neither blocked: occupancy is unchanged and both pointers advance.
- Payload tracking:
  - Reading a header word loads `pkt_left` = `header[DATA_W-1:2]` + 1.
  - Each subsequent accepted read of a non-header word decrements `pkt_left`, saturating at 0.
  - When `pkt_left` is 0 and no read is accepted, `dataout` is driven to 0. This is the idle value, replacing the legacy tri-state.
- `pkt_cnt`: +1 on an accepted write with `lfd_state`=1; -1 on an accepted read of a header word; net 0 if both occur in one cycle.
- `soft_reset`: at the next edge clears pointers, occupancy, `pkt_cnt`, `pkt_left` and `dataout` (to 0). It dominates a same-cycle `write_en`/`read_en`. `err` is not cleared.
- Wrap-around: pointers roll from `DEPTH`-1 to 0 with the wrap bit toggling. Must be correct for any power-of-two `DEPTH`.

Optional Feature:
- Macro `ROUTER_FIFO_ERR_EN`.
- Defined: `err` sets on a write attempted while `full` or a read attempted while `empty`. Only `reset` clears it.
- Undefined: `err` is tied to 0 and no logic is inferred.

Decomposition:
- Package `router_pkg`:
  - `HDR_LSB`=2 (header length field low bit).
  - Function `clog2_safe`.
  - Typedef `fifo_word_t` with fields `{sof, data}`.
- Sub-module `router_fifo_mem`: simple dual-port register array, one write port and one synchronous read port, no reset.
- All control (pointers, counters, payload tracker) stays in `router_fifo_pkt`.

Test Plan:
- Reset/idle: assert `reset` mid-stream with 5 words stored -> same cycle, `empty`=1, `full`=0, `dataout`=0, `pkt_cnt`=0.
- Packet pass: write header 8'h0C (len 3) with `lfd_state`=1, then payload 8'hA1, A2, A3 and parity 8'h5F; then read 5 times ->
  - `dataout` sequence 0C, A1, A2, A3, 5F, one cycle after each `read_en`.
  - `rd_sof`=1 only with 0C.
  - `pkt_left` sequence 4, 3, 2, 1, 0.
  - `pkt_cnt` 1->0.
- Full/overflow: 17 writes of $random into `DEPTH`=16 -> `full`=1 after the 16th write, the 17th is dropped, `almost_full`=1 from the 14th write. With `ROUTER_FIFO_ERR_EN` defined, `err`=1.
- Wrap and simultaneous: fill 10 words, then 30 cycles of `read_en`=`write_en`=1 -> occupancy stays at 10 throughout, data remains in FIFO order across the pointer wrap.
- `soft_reset`: 6 words stored, `soft_reset` pulsed together with `write_en` -> next edge `empty`=1, `pkt_cnt`=0, `dataout`=0, the write is dropped, `err` is unchanged.
- Underflow: `read_en` held for 3 cycles while empty -> `dataout` holds its value, pointers unchanged, and `err`=1 only when the macro is defined.
